// File: rtl/uart_csr_arbiter.sv
// Two-requester round-robin arbiter sharing the UART CSR write/read port.
// Requester 0 is the host bus adapter, requester 1 the config/poll sequencer.
// One transaction is in flight at a time: IDLE -> ISSUE -> (RDWAIT) -> RESP.
module uart_csr_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_we0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_done0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_csr_wr_addr,
  output logic [DATA_W-1:0] o_csr_wr_data,
  output logic              o_csr_wen,
  output logic [ADDR_W-1:0] o_csr_rd_addr,
  output logic              o_csr_ren,
  input  logic [DATA_W-1:0] i_csr_rd_data,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_prio;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_id;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_anyReq;
  logic                w_grant1;

  // A lone requester always wins; prio only breaks a tie.
  assign w_anyReq = i_req0 | i_req1;
  assign w_grant1 = i_req1 & (~i_req0 | r_prio);

  // Both CSR address ports follow the latched command address.
  assign o_csr_wr_addr = r_addr;
  assign o_csr_rd_addr = r_addr;
  assign o_csr_wr_data = r_wdata;
  assign o_rdata0      = r_rdata0;
  assign o_rdata1      = r_rdata1;

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and strobe/done decode from the current state.
  always_comb begin
    w_next    = r_state;
    o_csr_wen = 1'b0;
    o_csr_ren = 1'b0;
    o_done0   = 1'b0;
    o_done1   = 1'b0;
    o_busy    = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_next = ISSUE;
        end
      end
      ISSUE: begin
        o_csr_wen = r_we;
        o_csr_ren = ~r_we;
        w_next    = r_we ? RESP : RDWAIT;
      end
      RDWAIT: begin
        w_next = RESP;
      end
      RESP: begin
        o_done0 = ~r_id;
        o_done1 = r_id;
        w_next  = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Latch the winner's command in IDLE so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_id    <= 1'b0;
    end else if (r_state == IDLE && w_anyReq) begin
      r_id    <= w_grant1;
      r_we    <= w_grant1 ? i_we1 : i_we0;
      r_addr  <= w_grant1 ? i_addr1 : i_addr0;
      r_wdata <= w_grant1 ? i_wdata1 : i_wdata0;
    end
  end

  // Hand priority to the other requester once a transaction completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (r_state == RESP) begin
      r_prio <= ~r_id;
    end
  end

  // Capture CSR read data for the served requester only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == RDWAIT) begin
      if (r_id) begin
        r_rdata1 <= i_csr_rd_data;
      end else begin
        r_rdata0 <= i_csr_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_csr_arbiter.sv
// Scoreboard bench for uart_csr_arbiter: directed requests push expected
// transactions; a monitor checks CSR strobes and done responses against them.
module tb_uart_csr_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              o_done0, o_done1;
  logic [DATA_W-1:0] o_rdata0, o_rdata1;
  logic [ADDR_W-1:0] o_csr_wr_addr, o_csr_rd_addr;
  logic [DATA_W-1:0] o_csr_wr_data;
  logic              o_csr_wen, o_csr_ren, o_busy;
  logic [DATA_W-1:0] csrRdData;

  logic [DATA_W-1:0] mem [0:255];

  typedef struct {
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t              expQ[$];
  int                testsRun = 0;
  int                testsFailed = 0;
  int                cyc = 0;
  int                lastIssue = 0;
  logic [DATA_W-1:0] expRdata0 = '0;
  logic [DATA_W-1:0] expRdata1 = '0;

  uart_csr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_we0(we0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_done0(o_done0), .o_rdata0(o_rdata0),
    .i_req1(req1), .i_we1(we1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_done1(o_done1), .o_rdata1(o_rdata1),
    .o_csr_wr_addr(o_csr_wr_addr), .o_csr_wr_data(o_csr_wr_data),
    .o_csr_wen(o_csr_wen), .o_csr_rd_addr(o_csr_rd_addr),
    .o_csr_ren(o_csr_ren), .i_csr_rd_data(csrRdData), .o_busy(o_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure issue-to-done spacing.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // CSR block model: registered read data, one cycle after ren.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[1] = 32'hA5A5_0001;
    mem[2] = 32'h0000_0005;
    csrRdData = '0;
    forever begin
      @(posedge clk);
      if (o_csr_wen) mem[o_csr_wr_addr] <= o_csr_wr_data;
      if (o_csr_ren) csrRdData <= mem[o_csr_rd_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares every strobe and done against the scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (o_csr_wen || o_csr_ren) begin
          checkOutput("strobe_excl", {31'd0, o_csr_wen & o_csr_ren}, 0);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_strobe", 1, 0);
          end else begin
            e = expQ[0];
            checkOutput("issue_we", {31'd0, o_csr_wen}, {31'd0, e.we});
            checkOutput("issue_wr_addr", {24'd0, o_csr_wr_addr}, {24'd0, e.addr});
            checkOutput("issue_rd_addr", {24'd0, o_csr_rd_addr}, {24'd0, e.addr});
            if (e.we) checkOutput("issue_wdata", o_csr_wr_data, e.wdata);
            lastIssue = cyc;
          end
        end
        if (o_done0 || o_done1) begin
          checkOutput("done_excl", {31'd0, o_done0 & o_done1}, 0);
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("done_id", {31'd0, o_done1}, {31'd0, e.id});
            checkOutput("issue_to_done", cyc - lastIssue, e.we ? 1 : 2);
            if (!e.we) begin
              if (e.id) expRdata1 = e.rdata;
              else      expRdata0 = e.rdata;
            end
            checkOutput("rdata0", o_rdata0, expRdata0);
            checkOutput("rdata1", o_rdata1, expRdata1);
          end
        end
      end
    end
  end

  // Wait for the done pulse of one requester, then drop its req on that edge.
  task automatic waitDone(input logic id, input int expK, input logic chkLat,
                          input logic doChange, input logic [ADDR_W-1:0] newAddr);
    int  k = 0;
    bit  seen = 0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (chkLat) checkOutput("busy", {31'd0, o_busy}, (k == 1) ? 0 : 1);
      if ((id ? o_done1 : o_done0) === 1'b1) begin
        seen = 1;
      end else if (doChange && k == 1) begin
        @(posedge clk);
        #1 addr0 = newAddr;
      end
    end
    checkOutput("done_seen", {31'd0, seen}, 1);
    if (seen && chkLat) checkOutput("done_latency", k, expK);
    @(posedge clk);
    #1;
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  // Issue one request from an idle arbiter and record its expected outcome.
  task automatic applyStimulus(input logic id, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                               input logic doChange, input logic [ADDR_W-1:0] newAddr);
    expQ.push_back('{id: id, we: we, addr: addr, wdata: wdata, rdata: rdata});
    if (id) begin
      we1 = we; addr1 = addr; wdata1 = wdata; req1 = 1'b1;
    end else begin
      we0 = we; addr0 = addr; wdata0 = wdata; req0 = 1'b1;
    end
    waitDone(id, we ? 3 : 4, 1'b1, doChange, newAddr);
  endtask

  // Directed sequence.
  initial begin
    int doneCnt;
    int k;
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = '0; wdata0 = 32'h1B2;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

    // Reset held with a pending request: nothing may be issued.
    repeat (5) begin
      @(negedge clk);
      checkOutput("rst_wen", {31'd0, o_csr_wen}, 0);
      checkOutput("rst_ren", {31'd0, o_csr_ren}, 0);
      checkOutput("rst_busy", {31'd0, o_busy}, 0);
      checkOutput("rst_done", {30'd0, o_done1, o_done0}, 0);
    end
    checkOutput("rst_rdata0", o_rdata0, 0);
    checkOutput("rst_rdata1", o_rdata1, 0);
    checkOutput("rst_wr_addr", {24'd0, o_csr_wr_addr}, 0);
    checkOutput("rst_wr_data", o_csr_wr_data, 0);
    @(posedge clk);
    #1 req0 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write, single read, then a read whose address changes mid-flight.
    applyStimulus(1'b0, 1'b1, 8'h00, 32'h0000_01B2, 32'h0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h02, 32'h0, 32'h0000_0005, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h01, 32'h0, 32'hA5A5_0001, 1'b1, 8'h02);

    // Both requesters held from reset: service must alternate 0,1,0,1.
    rst_n = 1'b0;
    #1;
    checkOutput("rst2_rdata0", o_rdata0, 0);
    expRdata0 = '0;
    expRdata1 = '0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h00;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h01;
    for (int i = 0; i < 2; i++) begin
      expQ.push_back('{id: 1'b0, we: 1'b0, addr: 8'h00, wdata: 32'h0, rdata: 32'h0000_01B2});
      expQ.push_back('{id: 1'b1, we: 1'b0, addr: 8'h01, wdata: 32'h0, rdata: 32'hA5A5_0001});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    doneCnt = 0;
    k = 0;
    while (doneCnt < 4 && k < 40) begin
      @(negedge clk);
      k++;
      if (o_done0 || o_done1) doneCnt++;
    end
    checkOutput("alt_done_count", doneCnt, 4);
    @(posedge clk);
    #1 req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;

    // Reset during RDWAIT of a requester 1 read, then a fresh read.
    expQ.push_back('{id: 1'b1, we: 1'b0, addr: 8'h02, wdata: 32'h0, rdata: 32'h0000_0005});
    we1 = 1'b0; addr1 = 8'h02; req1 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, o_busy}, 0);
    checkOutput("abort_done1", {31'd0, o_done1}, 0);
    checkOutput("abort_rdata1", o_rdata1, 0);
    checkOutput("abort_rdata0", o_rdata0, 0);
    checkOutput("abort_strobes", {30'd0, o_csr_wen, o_csr_ren}, 0);
    void'(expQ.pop_front());
    expRdata0 = '0;
    expRdata1 = '0;
    @(negedge clk);
    checkOutput("abort_done1_later", {31'd0, o_done1}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    expQ.push_back('{id: 1'b1, we: 1'b0, addr: 8'h02, wdata: 32'h0, rdata: 32'h0000_0005});
    waitDone(1'b1, 4, 1'b1, 1'b0, 8'h00);

    repeat (3) @(posedge clk);
    checkOutput("queue_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/uart_csr_arbiter.md
Name: uart_csr_arbiter

Overview:
Two-requester access arbiter in front of the UART CSR block. It shares the single CSR write/read port between a host bus adapter (requester 0) and an on-chip configuration/poll sequencer (requester 1). Requests are served one at a time with round-robin priority. The arbiter drives the CSR write/read strobes and returns read data to the winning requester with a done pulse.

Parameters:
ADDR_W, 8, CSR address width; matches the CSR block address width
DATA_W, 32, CSR data width; matches the CSR block data width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req0  in  1  requester 0 request; held until done0
we0  in  1  requester 0: 1=write, 0=read
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
done0  out  1  requester 0 transaction complete, 1-cycle pulse
rdata0  out  DATA_W  requester 0 read data, valid with done0 and held
req1, we1, addr1, wdata1, done1, rdata1  as above for requester 1
csr_wr_addr  out  ADDR_W  to CSR wr_addr
csr_wr_data  out  DATA_W  to CSR wr_data
csr_wen  out  1  to CSR wen
csr_rd_addr  out  ADDR_W  to CSR rd_addr
csr_ren  out  1  to CSR ren
csr_rd_data  in  DATA_W  from CSR rd_data; registered in CSR, valid 1 cycle after csr_ren
busy  out  1  arbiter state != IDLE

Behaviour:
- Reset (async): state=IDLE, prio=0, latched cmd regs=0, done0/1=0, rdata0/1=0, csr_wen=csr_ren=0, csr addr/data outputs=0, busy=0.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE: if req0|req1, select the winner, latch we/addr/wdata/id of the winner, and go to ISSUE. Otherwise stay in IDLE.
- Winner selection: if only one requester is active, it wins. If both are active, the requester indicated by prio wins.
- ISSUE, exactly 1 cycle:
  - Write: csr_wen=1. csr_wr_addr and csr_wr_data are driven from the latched regs. Next state RESP.
  - Read: csr_ren=1. csr_rd_addr is driven from the latched addr. Next state RDWAIT.
- RDWAIT: capture csr_rd_data into rdata of the latched requester id; go to RESP.
- RESP: done of the latched id = 1 for this cycle only. prio = the other requester id. Go to IDLE.
- Strobe rules:
  - csr_wen and csr_ren are never both high.
  - Neither is high outside ISSUE.
  - csr_wr_addr and csr_rd_addr both carry the latched addr at all times.
- Latency, measured from the IDLE cycle T in which req is sampled:
  - Write: wen at T+1, done at T+2.
  - Read: ren at T+1, rdata updated and done at T+3.
- Requester rule: req is deasserted on the clock edge ending the done cycle. A req still high in the following IDLE cycle is a new transaction.
- Requester inputs that change after latching are ignored until the next IDLE.
- rdata of the non-served requester is never modified. Write transactions never modify rdata.
- Back-to-back operation: with both requesters continuously requesting, service alternates 0,1,0,1,…. A single requester is never stalled by prio.
- Reset mid-transaction: the FSM aborts to IDLE immediately, no done is issued, all strobes drop, and prio returns to 0.
- No address decoding or range checks; all errors are reported by the CSR block.

Test Plan:
- Reset -> all outputs 0, busy=0; hold reset 5 cycles with req0=1 -> no csr_wen/csr_ren.
- req0 write addr=0x00 data=0x000001B2 -> csr_wen=1 for exactly cycle T+1 with csr_wr_addr=0x00, csr_wr_data=0x1B2; done0 pulse at T+2; rdata0 unchanged.
- req1 read addr=0x02 with CSR model returning 0x5 -> csr_ren=1 only at T+1, csr_rd_addr=0x02; rdata1=0x5 and done1 pulse at T+3; busy=1 for T+1..T+3.
- req0 and req1 both held from reset for 4 transactions (reads of 0x0, 0x1) -> service order 0,1,0,1; no cycle with csr_wen&csr_ren.
- req0 read addr=0x1, with addr0 changed to 0x2 during ISSUE -> csr_rd_addr stays 0x1; returned data is from 0x1.
- Assert rst_n=0 during RDWAIT of a req1 read -> no done1, rdata1=0, state IDLE. After release with req1 still high -> fresh read completes at T+3.
